// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Responder for MEM-stage load/store requests (mct_*). Each request
//            is serialised into 1, 2 or 4 byte accesses on a byte-wide
//            synchronous RAM with read latency 1. Load data is assembled
//            little-endian and zero-extended. A one-cycle mct_ok pulse marks
//            completion.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            mct_e/wr/a/cu   - request valid, store flag, byte address, size
//            mct_n_i         - store data (byte 0 = bits [7:0])
//            mct_n_o         - load data, held until the next load completes
//            mct_ok          - completion pulse, one cycle wide
//            ram_a/wr/dout   - RAM byte address, write enable, write byte
//            ram_din         - RAM read byte, valid one cycle after ram_a
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mct_e,
  input  logic              mct_wr,
  input  logic [31:0]       mct_a,
  input  logic [31:0]       mct_n_i,
  input  logic [1:0]        mct_cu,
  output logic [31:0]       mct_n_o,
  output logic              mct_ok,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Transaction state
  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         asm_q, asm_d;

  // Registered outputs
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic                ram_wr_q, ram_wr_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                mct_ok_q, mct_ok_d;
  logic [31:0]         mct_n_o_q, mct_n_o_d;

  // Helpers
  logic [2:0]          idx_inc;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [2:0]          req_n;
  logic [7:0]          store_byte_nxt;

  // Only the low ADDR_W address bits reach the RAM. Offsets are added in
  // ADDR_W-bit arithmetic, which equals a 32-bit add followed by truncation.
  generate
    if (ADDR_W < 32) begin : g_addr_trunc
      logic unused_addr_hi;
      assign unused_addr_hi = &{1'b0, mct_a[31:ADDR_W]};
    end
  endgenerate

  assign idx_inc  = idx_q + 3'd1;
  assign addr_nxt = addr_q + {{(ADDR_W-3){1'b0}}, idx_inc};

  always_comb begin
    req_n = 3'd4;
    case (mct_cu)
      2'd2:    req_n = 3'd2;
      2'd3:    req_n = 3'd1;
      default: req_n = 3'd4;
    endcase
  end

  // Store byte for the access following the current one
  always_comb begin
    store_byte_nxt = data_q[7:0];
    case (idx_inc[1:0])
      2'd0: store_byte_nxt = data_q[7:0];
      2'd1: store_byte_nxt = data_q[15:8];
      2'd2: store_byte_nxt = data_q[23:16];
      2'd3: store_byte_nxt = data_q[31:24];
      default: store_byte_nxt = data_q[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    addr_d     = addr_q;
    data_d     = data_q;
    asm_d      = asm_q;
    ram_a_d    = ram_a_q;
    ram_wr_d   = 1'b0;
    ram_dout_d = ram_dout_q;
    mct_ok_d   = 1'b0;
    mct_n_o_d  = mct_n_o_q;

    case (state_q)
      S_IDLE: begin
        if (mct_e) begin
          addr_d  = mct_a[ADDR_W-1:0];
          data_d  = mct_n_i;
          n_d     = req_n;
          idx_d   = 3'd0;
          asm_d   = 32'd0;
          // First access is presented in the cycle right after acceptance
          ram_a_d = mct_a[ADDR_W-1:0];
          if (mct_wr) begin
            state_d    = S_WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = mct_n_i[7:0];
          end else begin
            state_d    = S_READ;
          end
        end
      end

      S_READ: begin
        // ram_din now carries the byte addressed in the previous cycle
        for (int b = 0; b < 4; b++) begin
          if (idx_q == 3'(b + 1)) begin
            asm_d[8*b +: 8] = ram_din;
          end
        end
        if (idx_q == n_q) begin
          state_d   = S_DONE;
          mct_ok_d  = 1'b1;
          mct_n_o_d = asm_d;
        end else begin
          idx_d = idx_inc;
          // The trailing capture cycle keeps the last address on the bus
          if (idx_inc < n_q) begin
            ram_a_d = addr_nxt;
          end
        end
      end

      S_WRITE: begin
        if (idx_inc == n_q) begin
          state_d  = S_DONE;
          mct_ok_d = 1'b1;
        end else begin
          idx_d      = idx_inc;
          ram_a_d    = addr_nxt;
          ram_dout_d = store_byte_nxt;
          ram_wr_d   = 1'b1;
        end
      end

      S_DONE: begin
        // Requests are not looked at here; a held mct_e is taken in IDLE
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      n_q        <= 3'd0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      asm_q      <= 32'd0;
      ram_a_q    <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= 8'd0;
      mct_ok_q   <= 1'b0;
      mct_n_o_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      asm_q      <= asm_d;
      ram_a_q    <= ram_a_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      mct_ok_q   <= mct_ok_d;
      mct_n_o_q  <= mct_n_o_d;
    end
  end

  assign ram_a    = ram_a_q;
  assign ram_wr   = ram_wr_q;
  assign ram_dout = ram_dout_q;
  assign mct_ok   = mct_ok_q;
  assign mct_n_o  = mct_n_o_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a behavioural
//            byte-wide RAM (read latency 1) and a backdoor preload port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              mct_e;
  logic              mct_wr;
  logic [31:0]       mct_a;
  logic [31:0]       mct_n_i;
  logic [1:0]        mct_cu;
  logic [31:0]       mct_n_o;
  logic              mct_ok;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mct_e    (mct_e),
    .mct_wr   (mct_wr),
    .mct_a    (mct_a),
    .mct_n_i  (mct_n_i),
    .mct_cu   (mct_cu),
    .mct_n_o  (mct_n_o),
    .mct_ok   (mct_ok),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din)
  );

  always #5 clk = ~clk;

  // RAM model with a backdoor write port for preloading
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_a  = '0;
  logic [7:0]        bd_d  = 8'd0;

  always @(posedge clk) begin
    ram_din <= mem[ram_a];
    if (ram_wr) mem[ram_a] <= ram_dout;
    if (bd_we)  mem[bd_a]  <= bd_d;
  end

  int checks = 0;
  int errors = 0;

  // Per-cycle log, index = cycles after the accepting edge
  logic [ADDR_W-1:0] la  [1:12];
  logic              lwr [1:12];
  logic [7:0]        ld  [1:12];
  logic              lok [1:12];
  int lat, okcnt, wrcnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    tick();
    bd_we = 1'b0;
  endtask

  // Issue one request (mct_e for exactly one edge) and log ncyc cycles
  task automatic txn(input logic wr, input logic [1:0] cu, input logic [31:0] a,
                     input logic [31:0] d, input int ncyc);
    mct_e = 1'b1; mct_wr = wr; mct_cu = cu; mct_a = a; mct_n_i = d;
    tick();
    mct_e = 1'b0;
    lat = 0; okcnt = 0; wrcnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      la[c] = ram_a; lwr[c] = ram_wr; ld[c] = ram_dout; lok[c] = mct_ok;
      if (mct_ok) begin
        okcnt++;
        if (lat == 0) lat = c;
      end
      if (ram_wr) wrcnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; mct_e = 1'b0; mct_wr = 1'b0; mct_a = 32'd0; mct_n_i = 32'd0; mct_cu = 2'd0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ok",   {31'd0, mct_ok}, 32'd0);
    chk("rst_n_o",  mct_n_o, 32'd0);
    chk("rst_ram_a", 32'(ram_a), 32'd0);
    chk("rst_wr",   {31'd0, ram_wr}, 32'd0);
    chk("rst_dout", {24'd0, ram_dout}, 32'd0);

    // Word load
    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    txn(1'b0, 2'd0, 32'h100, 32'd0, 8);
    for (int c = 1; c <= 4; c++) chk("wl_ram_a", 32'(la[c]), 32'h100 + 32'(c - 1));
    chk("wl_lat",   lat, 6);
    chk("wl_okcnt", okcnt, 1);
    chk("wl_wrcnt", wrcnt, 0);
    chk("wl_data",  mct_n_o, 32'h44332211);

    // Half load, no sign extension
    poke(17'h20, 8'hCD); poke(17'h21, 8'hAB);
    txn(1'b0, 2'd2, 32'h20, 32'd0, 6);
    chk("hl_lat",   lat, 4);
    chk("hl_okcnt", okcnt, 1);
    chk("hl_data",  mct_n_o, 32'h0000ABCD);

    // Byte store
    txn(1'b1, 2'd3, 32'h7, 32'hDEADBE5A, 5);
    chk("bs_wrcnt", wrcnt, 1);
    chk("bs_wr1",   {31'd0, lwr[1]}, 32'd1);
    chk("bs_ram_a", 32'(la[1]), 32'h7);
    chk("bs_dout",  {24'd0, ld[1]}, 32'h5A);
    chk("bs_lat",   lat, 2);
    chk("bs_mem",   {24'd0, mem[7]}, 32'h5A);

    // Word store
    txn(1'b1, 2'd0, 32'h10, 32'h01020304, 7);
    chk("ws_wrcnt", wrcnt, 4);
    for (int c = 1; c <= 4; c++) begin
      chk("ws_ram_a", 32'(la[c]), 32'h10 + 32'(c - 1));
      chk("ws_dout",  {24'd0, ld[c]}, 32'(5 - c));
    end
    chk("ws_lat",   lat, 5);
    chk("ws_n_o_held", mct_n_o, 32'h0000ABCD);

    // Reset in READ index 2
    poke(17'h200, 8'hA0); poke(17'h201, 8'hA1); poke(17'h202, 8'hA2); poke(17'h203, 8'hA3);
    mct_e = 1'b1; mct_wr = 1'b0; mct_cu = 2'd0; mct_a = 32'h200;
    tick();
    mct_e = 1'b0;
    tick(); tick();
    chk("rm_ram_a_pre", 32'(ram_a), 32'h202);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_ok",    {31'd0, mct_ok}, 32'd0);
    chk("rm_n_o",   mct_n_o, 32'd0);
    chk("rm_ram_a", 32'(ram_a), 32'd0);
    chk("rm_wr",    {31'd0, ram_wr}, 32'd0);
    chk("rm_dout",  {24'd0, ram_dout}, 32'd0);
    okcnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (mct_ok) okcnt++;
      tick();
    end
    chk("rm_no_ok", okcnt, 0);
    txn(1'b0, 2'd3, 32'h201, 32'd0, 5);
    chk("rm_bl_lat",  lat, 3);
    chk("rm_bl_data", mct_n_o, 32'h000000A1);

    // Held mct_e: second request accepted in the IDLE cycle after DONE
    poke(17'h30, 8'h77); poke(17'h31, 8'h88);
    mct_e = 1'b1; mct_wr = 1'b0; mct_cu = 2'd3; mct_a = 32'h30;
    tick();
    okcnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) mct_a = 32'h31;
      if (c == 5) mct_e = 1'b0;
      lok[c] = mct_ok; la[c] = ram_a;
      if (mct_ok) okcnt++;
      if (c == 3) chk("bb_data1", mct_n_o, 32'h77);
      tick();
    end
    chk("bb_okcnt", okcnt, 2);
    chk("bb_ok3",   {31'd0, lok[3]}, 32'd1);
    chk("bb_ok4",   {31'd0, lok[4]}, 32'd0);
    chk("bb_ok7",   {31'd0, lok[7]}, 32'd1);
    chk("bb_ok8",   {31'd0, lok[8]}, 32'd0);
    chk("bb_ram_a2", 32'(la[5]), 32'h31);
    chk("bb_data2", mct_n_o, 32'h88);

    // Address wrap at the top of the RAM (cu=1 behaves as word)
    poke(17'h1FFFE, 8'h55); poke(17'h1FFFF, 8'h66); poke(17'h0, 8'h77); poke(17'h1, 8'h88);
    txn(1'b0, 2'd1, 32'h1FFFE, 32'd0, 8);
    chk("wr_ram_a1", 32'(la[1]), 32'h1FFFE);
    chk("wr_ram_a2", 32'(la[2]), 32'h1FFFF);
    chk("wr_ram_a3", 32'(la[3]), 32'h0);
    chk("wr_ram_a4", 32'(la[4]), 32'h1);
    chk("wr_lat",    lat, 6);
    chk("wr_data",   mct_n_o, 32'h88776655);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder end of the MEM-stage memory request interface (mct_*).
- Accepts one load/store request at a time from the MEM stage and serialises it into byte accesses on a byte-wide synchronous RAM.
- Returns assembled little-endian load data and a one-cycle mct_ok completion pulse.
- Sits between the MEM stage and the RAM port.

Parameters:
- ADDR_W, 17, width of the RAM address bus; low ADDR_W bits of the byte address are driven.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- mct_e  in  1  request valid from MEM stage
- mct_wr  in  1  1 = store, 0 = load
- mct_a  in  32  byte address of first byte
- mct_n_i  in  32  store data; byte 0 = bits [7:0]
- mct_cu  in  2  size: 0 = word (4 bytes), 1 = word (4 bytes, treated as 0), 2 = half (2 bytes), 3 = byte (1 byte)
- mct_n_o  out  32  load data, zero-extended; requester performs sign extension
- mct_ok  out  1  completion pulse, exactly one cycle
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write enable
- ram_dout  out  8  byte to RAM
- ram_din  in  8  byte from RAM; valid one cycle after the address is presented (read latency 1)

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, index=0.
  - Outputs become 0: mct_ok, mct_n_o, ram_a, ram_wr, ram_dout.
  - Reset mid-transaction aborts it: no mct_ok is issued, and ram_wr=0 from the next cycle.
- Byte count N:
  - cu=0 or 1 → N=4
  - cu=2 → N=2
  - cu=3 → N=1
- Address arithmetic: byte i goes to (mct_a + i) mod 2^32, truncated to ADDR_W bits. Wrap-around is silent.
- IDLE:
  - Outputs: ram_wr=0, mct_ok=0.
  - If mct_e=1 at the edge, latch address, wr, cu, store data and N; set index=0.
  - Next state: READ if wr=0, WRITE if wr=1.
- READ (index runs 0..N, i.e. N+1 cycles):
  - Cycles with index<N: drive ram_a = addr+index, ram_wr=0.
  - Cycle with index=N: ram_a holds its last value.
  - At the end of each cycle with index≥1: capture ram_din into byte (index-1) of the assembly register.
  - After index=N, go to DONE.
  - Bytes above N-1 are zero.
- WRITE (index runs 0..N-1, i.e. N cycles):
  - Each cycle: drive ram_a = addr+index, ram_dout = store byte index, ram_wr=1.
  - After index=N-1, go to DONE.
- DONE (1 cycle):
  - Outputs: mct_ok=1, ram_wr=0.
  - For a load, mct_n_o = assembled value. For a store, mct_n_o is unchanged.
  - Next state: IDLE.
- Latency, counted in cycles after the accepting edge:
  - Load: mct_ok high in cycle N+2 (word 6, half 4, byte 3).
  - Store: mct_ok high in cycle N+1 (word 5, half 3, byte 2).
- mct_n_o holds its value until the next load completes.
- Requester rules:
  - Request fields are sampled only at the accepting edge. Changes to mct_e, mct_a, mct_wr, mct_cu or mct_n_i during READ/WRITE/DONE are ignored, and the transaction always completes.
  - The requester must drop mct_e in the mct_ok cycle. If mct_e is still 1 in the IDLE cycle after DONE, that is a new request and is accepted. Back-to-back transactions therefore have a minimum of one IDLE cycle between them.
- Only one outstanding request; no queueing.

Test Plan:
- Word load:
  - Stimulus: RAM[0x100..0x103] = 11,22,33,44; request e=1, wr=0, cu=0, a=0x100.
  - Required: ram_a = 0x100..0x103 in cycles 1-4; mct_ok only in cycle 6; mct_n_o = 0x44332211.
- Half load:
  - Stimulus: RAM[0x20]=0xCD, RAM[0x21]=0xAB; request cu=2, a=0x20.
  - Required: mct_ok in cycle 4; mct_n_o = 0x0000ABCD (no sign extension).
- Byte store, then word store:
  - Stimulus: byte store cu=3, a=0x7, n_i=0xDEADBE5A; then word store a=0x10, n_i=0x01020304.
  - Required, byte store: one ram_wr pulse, ram_a=0x7, ram_dout=0x5A, mct_ok in cycle 2.
  - Required, word store: ram_dout = 04,03,02,01 at 0x10..0x13, mct_ok in cycle 5.
- Reset mid-load:
  - Stimulus: word load started; rst=1 in READ index 2.
  - Required: next cycle state IDLE, all outputs 0, no mct_ok ever; a following byte load completes normally.
- Back-to-back and held e:
  - Stimulus: mct_e held at 1 through the DONE cycle of a byte load.
  - Required: a second transaction is accepted from the IDLE cycle immediately after DONE; mct_ok pulses twice, each exactly 1 cycle wide.
- Address wrap:
  - Stimulus: word load at a = 2^ADDR_W - 2.
  - Required: ram_a sequence = 2^ADDR_W-2, 2^ADDR_W-1, 0, 1.
